ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch bus unit between the PC register / fetch stage and the instruction bus. It accepts a PC from the PC register and issues one `ibus_req_t` transaction per PC. It captures the `ibus_resp_t` data into a hold buffer and presents `{pc, instr}` to the fetch stage until that stage consumes it. It also handles branch redirects by dropping stale data, including responses that are still in flight.

## Interface
- No parameters. Types `ibus_req_t`, `ibus_resp_t`, `u64`, `u32` come from package `common`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_i`  in  64  next fetch address from the PC register.
- `fetch_en`  in  1  `pc_i` is valid and requested.
- `redirect_i`  in  1  branch taken in execute. `pc_i` this cycle is the branch target; all older fetch state is stale.
- `ready_i`  in  1  fetch stage consumes the presented instruction this cycle (derived from `~stallD`).
- `accept_o`  out  1  `pc_i` latched this cycle; the PC register advances only when this is high.
- `ireq`  out  `ibus_req_t`  `{valid, addr}` to the instruction bus.
- `iresp`  in  `ibus_resp_t`  `{addr_ok, data_ok, data[31:0]}` from the instruction bus.
- `valid_o`  out  1  `instr_o` / `pc_o` / `misalign_o` are valid.
- `instr_o`  out  32  fetched instruction.
- `pc_o`  out  64  address of `instr_o`.
- `misalign_o`  out  1  `pc_o[1:0] != 0`; `instr_o` = 0 and no bus access was made.

## Operation
- FSM states: IDLE, WAIT, HOLD, DRAIN.
- Registers: `req_pc` (64), `buf_instr` (32), `buf_mis` (1).
- Accept condition: `accept_o = fetch_en && (state==IDLE || (state==HOLD && (ready_i || redirect_i)))`.
- On accept, `pc_i` is latched into `req_pc`:
  - `pc_i[1:0]==0`: next state WAIT.
  - otherwise: `buf_mis`=1, `buf_instr`=0, next state HOLD, with no bus request.
- IDLE:
  - `ireq.valid`=0 and `valid_o`=0.
  - Accept if `fetch_en`; otherwise stay in IDLE.
- WAIT:
  - `ireq.valid`=1 and `ireq.addr`=`req_pc`, held stable until `data_ok`. `addr_ok` is ignored; the request is complete only on `data_ok`.
  - `data_ok` and no redirect: `buf_instr`=`iresp.data`, `buf_mis`=0, go to HOLD.
  - `data_ok` with redirect: discard data, go to IDLE.
  - Redirect without `data_ok`: go to DRAIN.
- HOLD:
  - `valid_o`=1, `instr_o`=`buf_instr`, `pc_o`=`req_pc`, `misalign_o`=`buf_mis`.
  - `redirect_i` (takes priority over `ready_i`): buffer dropped. If `fetch_en`, accept the target; otherwise go to IDLE.
  - `ready_i`: accept next PC if `fetch_en`; otherwise go to IDLE.
  - Neither: stay in HOLD with outputs stable.
- DRAIN:
  - `ireq.valid`=1 with the old `req_pc` (bus transactions are never abandoned); `valid_o`=0.
  - On `data_ok`: discard data, go to IDLE.
  - The target PC is held in the PC register because `accept_o`=0, and is accepted from IDLE.
- `redirect_i` in IDLE has no extra effect; `pc_i` is already the target.
- `valid_o` is 0 in IDLE, WAIT and DRAIN. `instr_o`, `pc_o` and `misalign_o` are don't-care when `valid_o`=0, but must not be X.

## Timing
- Reset: state IDLE, `req_pc`=0, `buf_instr`=0, `buf_mis`=0, `ireq.valid`=0, `valid_o`=0, `accept_o`=0.
- `reset` asserted mid-transaction forces IDLE on the next edge. The memory model is reset in the same cycle, so no drain is needed.
- Latency, zero-wait memory:
  - accept in cycle 0;
  - WAIT in cycle 1 with `data_ok` in the same cycle;
  - `valid_o` in cycle 2.
  - Each additional memory wait cycle adds 1.
- Throughput: one instruction per 2 cycles with zero-wait memory and `ready_i`=1. Acceptance in HOLD overlaps consumption, so there is no idle bubble.
- Misaligned PC: accept in cycle 0, `valid_o`+`misalign_o` in cycle 1, and `ireq.valid` never asserts.
- `accept_o` and `ireq` are combinational from state and inputs only. There is no combinational path from `iresp` to `ireq` or to `accept_o`.
- `ireq.addr` must not change while `ireq.valid`=1 and `data_ok` has not yet been seen.
- Redirect from DRAIN: the target PC is accepted in the cycle after `data_ok`.

## Test plan
- Straight-line fetch: PC 0x8000_0000, +4, +8 with zero-wait memory and `ready_i`=1 → `valid_o` in cycles 2, 4, 6 with matching `pc_o`/`instr_o`.
- Memory latency: `data_ok` delayed 3 cycles → `ireq.valid`=1 with `addr` stable for 4 cycles; `valid_o` one cycle after `data_ok`.
- Back-pressure: `ready_i`=0 for 5 cycles in HOLD → `instr_o`/`pc_o` stable, `accept_o`=0, `ireq.valid`=0; on `ready_i`=1, the next PC is accepted in the same cycle.
- In-flight redirect: redirect to 0x8000_0100 while WAIT on 0x8000_0008, with `data_ok` 2 cycles later → DRAIN, old data never on `valid_o`, next valid `pc_o`=0x8000_0100.
- Redirect in HOLD and simultaneous redirect+`data_ok` in WAIT → buffered or arriving instruction dropped; first valid `pc_o` is the target.
- Misaligned PC 0x8000_0002 → `valid_o`=1, `misalign_o`=1, `instr_o`=0, no bus request. Reset asserted in WAIT → IDLE next cycle with all outputs at reset values.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch bus unit: issues one bus request per accepted PC, buffers the
// returned instruction for the fetch stage and drops stale data on branch redirects.
package common;
    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;
endpackage

module ifetch_unit
    import common::*;
(
    input  logic       clk,
    input  logic       reset,
    input  u64         pc_i,
    input  logic       fetch_en,
    input  logic       redirect_i,
    input  logic       ready_i,
    output logic       accept_o,
    output ibus_req_t  ireq,
    input  ibus_resp_t iresp,
    output logic       valid_o,
    output u32         instr_o,
    output u64         pc_o,
    output logic       misalign_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;
    u64     r_req_pc;
    u32     r_buf_instr;
    logic   r_buf_mis;

    logic   w_accept;
    logic   w_aligned;
    logic   w_capture;
    logic   w_unused_addr_ok;

    // Completion is signalled by data_ok alone; addr_ok carries no meaning here.
    assign w_unused_addr_ok = iresp.addr_ok;

    always_comb begin
        w_accept  = fetch_en && ((r_state == IDLE) ||
                                 ((r_state == HOLD) && (ready_i || redirect_i)));
        w_aligned = (pc_i[1:0] == 2'b00);
        w_capture = (r_state == WAIT) && iresp.data_ok && !redirect_i;
        w_next    = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = w_aligned ? WAIT : HOLD;
            end
            WAIT: begin
                if (iresp.data_ok)   w_next = redirect_i ? IDLE : HOLD;
                else if (redirect_i) w_next = DRAIN;
            end
            HOLD: begin
                // Redirect and consume both release the buffer; a new PC may refill it at once.
                if (redirect_i || ready_i) begin
                    if (w_accept) w_next = w_aligned ? WAIT : HOLD;
                    else          w_next = IDLE;
                end
            end
            DRAIN: begin
                if (iresp.data_ok) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_pc    <= '0;
            r_buf_instr <= '0;
            r_buf_mis   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_req_pc <= pc_i;
                if (!w_aligned) begin
                    r_buf_mis   <= 1'b1;
                    r_buf_instr <= '0;
                end
            end
            if (w_capture) begin
                r_buf_instr <= iresp.data;
                r_buf_mis   <= 1'b0;
            end
        end
    end

    assign accept_o   = w_accept;
    assign ireq.valid = (r_state == WAIT) || (r_state == DRAIN);
    assign ireq.addr  = r_req_pc;
    assign valid_o    = (r_state == HOLD);
    assign instr_o    = r_buf_instr;
    assign pc_o       = r_req_pc;
    assign misalign_o = r_buf_mis;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// compared against a bus/buffer transaction model.
module tb_ifetch_unit;
    import common::*;

    localparam u64 BASE = 64'h8000_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    u64         pc_i = '0;
    logic       fetch_en = 1'b0;
    logic       redirect_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       accept_o;
    ibus_req_t  ireq;
    ibus_resp_t iresp = '0;
    logic       valid_o;
    u32         instr_o;
    u64         pc_o;
    logic       misalign_o;

    int vectors = 0;
    int errors  = 0;

    // Reference model: one outstanding bus transaction and one output buffer.
    logic        m_busy, m_stale, m_full, m_mis;
    u64          m_addr, m_pc, pc_reg;
    u32          m_instr;
    logic        mem_active;
    int unsigned mem_lat;

    ifetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_i       (pc_i),
        .fetch_en   (fetch_en),
        .redirect_i (redirect_i),
        .ready_i    (ready_i),
        .accept_o   (accept_o),
        .ireq       (ireq),
        .iresp      (iresp),
        .valid_o    (valid_o),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .misalign_o (misalign_o)
    );

    always #5 clk = ~clk;

    function automatic u32 mem_data(input u64 a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Apply inputs 1ns after the rising edge and return at the falling edge.
    task automatic drive(input logic fe, input logic rdy, input logic rd, input u64 pc,
                         input logic dok, input u32 d);
        @(posedge clk);
        #1;
        fetch_en = fe; ready_i = rdy; redirect_i = rd; pc_i = pc;
        iresp.addr_ok = 1'b1; iresp.data_ok = dok; iresp.data = d;
        #4;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 0, 0, 64'h0, 0, 32'h0);
        drive(0, 0, 0, 64'h0, 0, 32'h0);
        vectors++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", valid_o); end
        vectors++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL rst_ireq: got %b exp 0", ireq.valid); end
        vectors++; if (accept_o !== 1'b0) begin errors++; $display("FAIL rst_accept: got %b exp 0", accept_o); end
        vectors++; if (pc_o !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h exp 0", pc_o); end
        vectors++; if (instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", instr_o); end
        vectors++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b exp 0", misalign_o); end
        reset = 1'b0;
    endtask

    task automatic test_straight_line;
        for (int c = 0; c < 8; c++) begin
            logic exp_v, exp_acc;
            u64   a;
            exp_v   = (c >= 2) && (c <= 6) && (c % 2 == 0);
            exp_acc = (c % 2 == 0) && (c <= 4);
            drive(c <= 5, 1, 0, BASE + 64'(4 * ((c + 1) / 2)), (c % 2 == 1) && (c <= 5),
                  mem_data(BASE + 64'(4 * ((c - 1) / 2))));
            vectors++; if (valid_o !== exp_v) begin errors++; $display("FAIL seq_valid c%0d: got %b exp %b", c, valid_o, exp_v); end
            vectors++; if (accept_o !== exp_acc) begin errors++; $display("FAIL seq_accept c%0d: got %b exp %b", c, accept_o, exp_acc); end
            if (exp_v) begin
                a = BASE + 64'(4 * (c / 2 - 1));
                vectors++; if (pc_o !== a) begin errors++; $display("FAIL seq_pc c%0d: got %h exp %h", c, pc_o, a); end
                vectors++; if (instr_o !== mem_data(a)) begin errors++; $display("FAIL seq_instr c%0d: got %h exp %h", c, instr_o, mem_data(a)); end
            end
            if ((c % 2 == 1) && (c <= 5)) begin
                a = BASE + 64'(4 * ((c - 1) / 2));
                vectors++; if (ireq.valid !== 1'b1 || ireq.addr !== a) begin errors++; $display("FAIL seq_req c%0d: got %b/%h exp 1/%h", c, ireq.valid, ireq.addr, a); end
            end
        end
    endtask

    task automatic test_latency;
        u64 a = BASE + 64'h40;
        drive(1, 1, 0, a, 0, 32'h0);
        vectors++; if (accept_o !== 1'b1) begin errors++; $display("FAIL lat_accept: got %b exp 1", accept_o); end
        for (int c = 1; c <= 4; c++) begin
            drive(1, 1, 0, a + 64'd4, c == 4, mem_data(a));
            vectors++; if (ireq.valid !== 1'b1 || ireq.addr !== a) begin errors++; $display("FAIL lat_req c%0d: got %b/%h exp 1/%h", c, ireq.valid, ireq.addr, a); end
            vectors++; if (valid_o !== 1'b0 || accept_o !== 1'b0) begin errors++; $display("FAIL lat_wait c%0d: got v%b a%b exp v0 a0", c, valid_o, accept_o); end
        end
        drive(0, 1, 0, a + 64'd4, 0, 32'h0);
        vectors++; if (valid_o !== 1'b1 || pc_o !== a || instr_o !== mem_data(a)) begin errors++; $display("FAIL lat_out: got %b/%h/%h exp 1/%h/%h", valid_o, pc_o, instr_o, a, mem_data(a)); end
    endtask

    task automatic test_backpressure;
        u64 a = BASE + 64'h80;
        drive(1, 0, 0, a, 0, 32'h0);
        vectors++; if (accept_o !== 1'b1) begin errors++; $display("FAIL bp_accept0: got %b exp 1", accept_o); end
        drive(1, 0, 0, a + 64'd4, 1, mem_data(a));
        for (int c = 2; c <= 6; c++) begin
            drive(1, 0, 0, a + 64'd4, 0, 32'h0);
            vectors++; if (valid_o !== 1'b1 || pc_o !== a || instr_o !== mem_data(a)) begin errors++; $display("FAIL bp_hold c%0d: got %b/%h/%h exp 1/%h/%h", c, valid_o, pc_o, instr_o, a, mem_data(a)); end
            vectors++; if (accept_o !== 1'b0 || ireq.valid !== 1'b0) begin errors++; $display("FAIL bp_quiet c%0d: got a%b r%b exp a0 r0", c, accept_o, ireq.valid); end
        end
        drive(1, 1, 0, a + 64'd4, 0, 32'h0);
        vectors++; if (accept_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL bp_release: got a%b v%b exp a1 v1", accept_o, valid_o); end
        drive(0, 1, 0, a + 64'd8, 1, mem_data(a + 64'd4));
        vectors++; if (ireq.valid !== 1'b1 || ireq.addr !== a + 64'd4) begin errors++; $display("FAIL bp_req2: got %b/%h exp 1/%h", ireq.valid, ireq.addr, a + 64'd4); end
        drive(0, 1, 0, a + 64'd8, 0, 32'h0);
        vectors++; if (valid_o !== 1'b1 || pc_o !== a + 64'd4) begin errors++; $display("FAIL bp_out2: got %b/%h exp 1/%h", valid_o, pc_o, a + 64'd4); end
    endtask

    task automatic test_redirect_inflight;
        u64 o = BASE + 64'h8;
        u64 t = BASE + 64'h100;
        drive(1, 1, 0, o, 0, 32'h0);
        drive(1, 1, 1, t, 0, 32'h0);
        vectors++; if (accept_o !== 1'b0 || ireq.addr !== o) begin errors++; $display("FAIL rdi_wait: got a%b %h exp a0 %h", accept_o, ireq.addr, o); end
        for (int c = 2; c <= 3; c++) begin
            drive(1, 1, 0, t, c == 3, mem_data(o));
            vectors++; if (ireq.valid !== 1'b1 || ireq.addr !== o) begin errors++; $display("FAIL rdi_drain_req c%0d: got %b/%h exp 1/%h", c, ireq.valid, ireq.addr, o); end
            vectors++; if (valid_o !== 1'b0 || accept_o !== 1'b0) begin errors++; $display("FAIL rdi_drain c%0d: got v%b a%b exp v0 a0", c, valid_o, accept_o); end
        end
        drive(1, 1, 0, t, 0, 32'h0);
        vectors++; if (accept_o !== 1'b1 || valid_o !== 1'b0 || ireq.valid !== 1'b0) begin errors++; $display("FAIL rdi_accept: got a%b v%b r%b exp a1 v0 r0", accept_o, valid_o, ireq.valid); end
        drive(0, 1, 0, t + 64'd4, 1, mem_data(t));
        vectors++; if (ireq.addr !== t || valid_o !== 1'b0) begin errors++; $display("FAIL rdi_req: got %h v%b exp %h v0", ireq.addr, valid_o, t); end
        drive(0, 1, 0, t + 64'd4, 0, 32'h0);
        vectors++; if (valid_o !== 1'b1 || pc_o !== t || instr_o !== mem_data(t)) begin errors++; $display("FAIL rdi_out: got %b/%h/%h exp 1/%h/%h", valid_o, pc_o, instr_o, t, mem_data(t)); end
    endtask

    task automatic test_redirect_hold;
        u64 x  = BASE + 64'h200;
        u64 t  = BASE + 64'h300;
        u64 y  = BASE + 64'h400;
        u64 t2 = BASE + 64'h500;
        drive(1, 1, 0, x, 0, 32'h0);
        drive(1, 0, 0, x + 64'd4, 1, mem_data(x));
        drive(1, 0, 1, t, 0, 32'h0);
        vectors++; if (valid_o !== 1'b1 || pc_o !== x || accept_o !== 1'b1) begin errors++; $display("FAIL rdh_hold: got v%b %h a%b exp v1 %h a1", valid_o, pc_o, accept_o, x); end
        drive(0, 1, 0, t + 64'd4, 1, mem_data(t));
        vectors++; if (valid_o !== 1'b0 || ireq.addr !== t) begin errors++; $display("FAIL rdh_req: got v%b %h exp v0 %h", valid_o, ireq.addr, t); end
        drive(0, 1, 0, t + 64'd4, 0, 32'h0);
        vectors++; if (valid_o !== 1'b1 || pc_o !== t || instr_o !== mem_data(t)) begin errors++; $display("FAIL rdh_out: got %b/%h/%h exp 1/%h/%h", valid_o, pc_o, instr_o, t, mem_data(t)); end
        drive(1, 1, 0, y, 0, 32'h0);
        drive(1, 1, 1, t2, 1, mem_data(y));
        vectors++; if (accept_o !== 1'b0) begin errors++; $display("FAIL rds_wait: got %b exp 0", accept_o); end
        drive(1, 1, 0, t2, 0, 32'h0);
        vectors++; if (valid_o !== 1'b0 || accept_o !== 1'b1) begin errors++; $display("FAIL rds_drop: got v%b a%b exp v0 a1", valid_o, accept_o); end
        drive(0, 1, 0, t2 + 64'd4, 1, mem_data(t2));
        vectors++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rds_wait2: got %b exp 0", valid_o); end
        drive(0, 1, 0, t2 + 64'd4, 0, 32'h0);
        vectors++; if (valid_o !== 1'b1 || pc_o !== t2 || instr_o !== mem_data(t2)) begin errors++; $display("FAIL rds_out: got %b/%h/%h exp 1/%h/%h", valid_o, pc_o, instr_o, t2, mem_data(t2)); end
    endtask

    task automatic test_misalign;
        u64 m = BASE + 64'h2;
        drive(1, 1, 0, m, 0, 32'h0);
        vectors++; if (accept_o !== 1'b1 || ireq.valid !== 1'b0) begin errors++; $display("FAIL mis_accept: got a%b r%b exp a1 r0", accept_o, ireq.valid); end
        drive(0, 1, 0, BASE + 64'd4, 0, 32'h0);
        vectors++; if (valid_o !== 1'b1 || misalign_o !== 1'b1 || instr_o !== 32'h0 || pc_o !== m) begin errors++; $display("FAIL mis_out: got %b/%b/%h/%h exp 1/1/0/%h", valid_o, misalign_o, instr_o, pc_o, m); end
        vectors++; if (ireq.valid !== 1'b0) begin errors++; $display("FAIL mis_noreq: got %b exp 0", ireq.valid); end
        drive(0, 1, 0, BASE + 64'd4, 0, 32'h0);
        vectors++; if (valid_o !== 1'b0 || ireq.valid !== 1'b0) begin errors++; $display("FAIL mis_idle: got v%b r%b exp v0 r0", valid_o, ireq.valid); end
    endtask

    task automatic test_reset_mid;
        u64 a = BASE + 64'h600;
        drive(1, 1, 0, a, 0, 32'h0);
        drive(0, 1, 0, a + 64'd4, 0, 32'h0);
        vectors++; if (ireq.valid !== 1'b1) begin errors++; $display("FAIL rsm_wait: got %b exp 1", ireq.valid); end
        reset = 1'b1;
        drive(0, 1, 0, a + 64'd4, 0, 32'h0);
        vectors++; if (ireq.valid !== 1'b0 || valid_o !== 1'b0 || accept_o !== 1'b0) begin errors++; $display("FAIL rsm_ctl: got r%b v%b a%b exp r0 v0 a0", ireq.valid, valid_o, accept_o); end
        vectors++; if (pc_o !== 64'h0 || instr_o !== 32'h0 || misalign_o !== 1'b0) begin errors++; $display("FAIL rsm_regs: got %h/%h/%b exp 0/0/0", pc_o, instr_o, misalign_o); end
        reset = 1'b0;
    endtask

    // Advance the model by one clock using the inputs held during the cycle just ended.
    task automatic model_update;
        logic acc;
        acc = fetch_en && !m_busy && (!m_full || ready_i || redirect_i);
        if (m_full && (ready_i || redirect_i)) m_full = 1'b0;
        if (m_busy && iresp.data_ok) begin
            m_busy     = 1'b0;
            mem_active = 1'b0;
            if (!m_stale && !redirect_i) begin
                m_full = 1'b1; m_pc = m_addr; m_instr = iresp.data; m_mis = 1'b0;
            end
        end else if (m_busy && redirect_i) begin
            m_stale = 1'b1;
        end
        if (acc) begin
            if (pc_i[1:0] == 2'b00) begin
                m_busy = 1'b1; m_addr = pc_i; m_stale = 1'b0;
            end else begin
                m_full = 1'b1; m_pc = pc_i; m_instr = '0; m_mis = 1'b1;
            end
            pc_reg = (pc_i & ~64'h3) + 64'd4;
        end
    endtask

    task automatic test_random;
        logic exp_acc;
        reset = 1'b1;
        drive(0, 0, 0, 64'h0, 0, 32'h0);
        reset = 1'b0;
        m_busy = 1'b0; m_stale = 1'b0; m_full = 1'b0; m_mis = 1'b0;
        m_addr = '0; m_pc = '0; m_instr = '0; pc_reg = BASE;
        mem_active = 1'b0; mem_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            model_update();
            #1;
            redirect_i = ($urandom_range(0, 9) == 0);
            if (redirect_i) begin
                pc_reg = BASE + 64'($urandom_range(0, 255)) * 64'd4;
                if ($urandom_range(0, 7) == 0) pc_reg[1] = 1'b1;
            end else if ($urandom_range(0, 24) == 0) begin
                pc_reg[1] = 1'b1;
            end
            fetch_en      = ($urandom_range(0, 7) != 0);
            ready_i       = ($urandom_range(0, 3) != 0);
            pc_i          = pc_reg;
            iresp.addr_ok = 1'($urandom_range(0, 1));
            iresp.data    = $urandom;
            iresp.data_ok = 1'b0;
            if (m_busy) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    mem_lat    = $urandom_range(0, 3);
                end
                if (mem_lat == 0) iresp.data_ok = 1'b1;
                else              mem_lat--;
            end
            #4;
            exp_acc = fetch_en && !m_busy && (!m_full || ready_i || redirect_i);
            vectors++; if (accept_o !== exp_acc) begin errors++; $display("FAIL rnd_accept i%0d: got %b exp %b", i, accept_o, exp_acc); end
            vectors++; if (ireq.valid !== m_busy) begin errors++; $display("FAIL rnd_ireq i%0d: got %b exp %b", i, ireq.valid, m_busy); end
            if (m_busy) begin
                vectors++; if (ireq.addr !== m_addr) begin errors++; $display("FAIL rnd_addr i%0d: got %h exp %h", i, ireq.addr, m_addr); end
            end
            vectors++; if (valid_o !== m_full) begin errors++; $display("FAIL rnd_valid i%0d: got %b exp %b", i, valid_o, m_full); end
            if (m_full) begin
                vectors++; if (pc_o !== m_pc || instr_o !== m_instr || misalign_o !== m_mis) begin errors++; $display("FAIL rnd_out i%0d: got %h/%h/%b exp %h/%h/%b", i, pc_o, instr_o, misalign_o, m_pc, m_instr, m_mis); end
            end
            vectors++; if ($isunknown({pc_o, instr_o, misalign_o})) begin errors++; $display("FAIL rnd_x i%0d: got %h/%h/%b exp no X", i, pc_o, instr_o, misalign_o); end
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_latency();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_hold();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
